// File: rtl/rtcalarm_bank.sv
// Bank of daily BCD time-of-day alarms with per-channel one-shot mode and snooze re-arm.
// Trips are qualified by a seconds tick derived from changes of i_now.
module rtcalarm_bank #(
    parameter int NALARMS     = 4,
    parameter int LGN         = 2,
    parameter int SNOOZE_SECS = 300,
    parameter int LGSNOOZE    = 10
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [21:0]        i_now,
    input  logic               i_wr,
    input  logic [LGN-1:0]     i_addr,
    input  logic               i_enable,
    input  logic               i_oneshot,
    input  logic               i_clear,
    input  logic               i_snooze,
    input  logic [21:0]        i_when,
    input  logic [2:0]         i_valid,
    output logic [31:0]        o_data,
    output logic [NALARMS-1:0] o_tripped,
    output logic               o_alarm
);

    localparam logic [LGSNOOZE-1:0] SnoozeLoad = LGSNOOZE'(SNOOZE_SECS);
    localparam logic [LGSNOOZE-1:0] SnoozeOne  = LGSNOOZE'(1);

    logic [21:0]         was;
    logic                tick;
    logic [NALARMS-1:0]  enabled, enabled_nxt;
    logic [NALARMS-1:0]  oneshot, oneshot_nxt;
    logic [NALARMS-1:0]  tripped, tripped_nxt;
    logic [NALARMS-1:0]  sel, match_trip, snz_trip;
    logic [21:0]         alarm_time     [NALARMS];
    logic [21:0]         alarm_time_nxt [NALARMS];
    logic [LGSNOOZE-1:0] snz            [NALARMS];
    logic [LGSNOOZE-1:0] snz_nxt        [NALARMS];
    logic [31:0]         rd_data;

    always_comb begin
        tick        = (i_now != was);
        enabled_nxt = enabled;
        oneshot_nxt = oneshot;
        tripped_nxt = tripped;
        sel         = '0;
        match_trip  = '0;
        snz_trip    = '0;
        rd_data     = '0;
        for (int k = 0; k < NALARMS; k++) begin
            alarm_time_nxt[k] = alarm_time[k];
            snz_nxt[k]        = snz[k];
            sel[k]        = i_wr && (i_addr == LGN'(k));
            match_trip[k] = tick && enabled[k] && (i_now == alarm_time[k]);
            snz_trip[k]   = tick && (snz[k] == SnoozeOne);

            if (match_trip[k] && oneshot[k]) enabled_nxt[k] = 1'b0;
            // Field writes land even when a trip happens in the same cycle
            if (sel[k]) begin
                enabled_nxt[k] = i_enable;
                oneshot_nxt[k] = i_oneshot;
                if (i_valid[0]) alarm_time_nxt[k][7:0]   = i_when[7:0];
                if (i_valid[1]) alarm_time_nxt[k][15:8]  = i_when[15:8];
                if (i_valid[2]) alarm_time_nxt[k][21:16] = i_when[21:16];
            end

            if (tick && (snz[k] > SnoozeOne)) snz_nxt[k] = snz[k] - SnoozeOne;

            if (match_trip[k] || snz_trip[k]) begin
                tripped_nxt[k] = 1'b1;
                if (snz_trip[k]) snz_nxt[k] = '0;
            end else if (sel[k] && i_clear) begin
                tripped_nxt[k] = 1'b0;
                snz_nxt[k]     = '0;
            end else if (sel[k] && i_snooze && tripped[k]) begin
                tripped_nxt[k] = 1'b0;
                snz_nxt[k]     = SnoozeLoad;
            end

            if (i_addr == LGN'(k)) begin
                rd_data = {6'h0, tripped[k], enabled[k], oneshot[k], (snz[k] != '0),
                           alarm_time[k]};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            was     <= '0;
            enabled <= '0;
            oneshot <= '0;
            tripped <= '0;
            o_data  <= '0;
            for (int k = 0; k < NALARMS; k++) begin
                alarm_time[k] <= '0;
                snz[k]        <= '0;
            end
        end else begin
            was     <= i_now;
            enabled <= enabled_nxt;
            oneshot <= oneshot_nxt;
            tripped <= tripped_nxt;
            o_data  <= rd_data;
            for (int k = 0; k < NALARMS; k++) begin
                alarm_time[k] <= alarm_time_nxt[k];
                snz[k]        <= snz_nxt[k];
            end
        end
    end

    assign o_tripped = tripped;
    assign o_alarm   = |tripped;

endmodule

// File: tb/tb_rtcalarm_bank.sv
// Self-checking bench for rtcalarm_bank: per-cycle model comparison plus directed literal checks.
module tb_rtcalarm_bank;
    localparam int NCH = 4;
    localparam int LGA = 3;
    localparam int SNZ = 300;

    logic           i_clk = 1'b0;
    logic           i_reset, i_wr, i_enable, i_oneshot, i_clear, i_snooze;
    logic [21:0]    i_now, i_when;
    logic [LGA-1:0] i_addr;
    logic [2:0]     i_valid;
    logic [31:0]    o_data;
    logic [NCH-1:0] o_tripped;
    logic           o_alarm;

    always #5 i_clk = ~i_clk;

    rtcalarm_bank #(
        .NALARMS    (NCH),
        .LGN        (LGA),
        .SNOOZE_SECS(SNZ),
        .LGSNOOZE   (10)
    ) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_now    (i_now),
        .i_wr     (i_wr),
        .i_addr   (i_addr),
        .i_enable (i_enable),
        .i_oneshot(i_oneshot),
        .i_clear  (i_clear),
        .i_snooze (i_snooze),
        .i_when   (i_when),
        .i_valid  (i_valid),
        .o_data   (o_data),
        .o_tripped(o_tripped),
        .o_alarm  (o_alarm)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: channel state as plain bits/ints, snooze as a countdown in seconds
    bit          m_en [NCH];
    bit          m_os [NCH];
    bit          m_tr [NCH];
    int          m_snz[NCH];
    logic [21:0] m_time[NCH];
    logic [21:0] m_was = '0;
    logic [31:0] m_data = '0;

    initial begin
        for (int k = 0; k < NCH; k++) begin
            m_en[k] = 0; m_os[k] = 0; m_tr[k] = 0; m_snz[k] = 0; m_time[k] = '0;
        end
    end

    function automatic logic [31:0] m_trvec();
        logic [31:0] v = '0;
        for (int k = 0; k < NCH; k++) v[k] = m_tr[k];
        return v;
    endfunction

    task automatic model_step();
        bit tick, wsel, tm, ts;
        int a;
        if (i_reset) begin
            for (int k = 0; k < NCH; k++) begin
                m_en[k] = 0; m_os[k] = 0; m_tr[k] = 0; m_snz[k] = 0; m_time[k] = '0;
            end
            m_was  = '0;
            m_data = '0;
            return;
        end
        tick   = (i_now != m_was);
        a      = int'(i_addr);
        m_data = '0;
        if (a < NCH) m_data = {6'h0, m_tr[a], m_en[a], m_os[a], (m_snz[a] != 0), m_time[a]};
        for (int k = 0; k < NCH; k++) begin
            wsel = i_wr && (a == k);
            tm   = tick && m_en[k] && (i_now == m_time[k]);
            ts   = tick && (m_snz[k] == 1);
            if (tick && m_snz[k] > 0) m_snz[k]--;
            if (tm && m_os[k]) m_en[k] = 0;
            if (wsel) begin
                m_en[k] = i_enable;
                m_os[k] = i_oneshot;
                if (i_valid[0]) m_time[k][7:0]   = i_when[7:0];
                if (i_valid[1]) m_time[k][15:8]  = i_when[15:8];
                if (i_valid[2]) m_time[k][21:16] = i_when[21:16];
            end
            if (tm || ts) begin
                m_tr[k] = 1;
            end else if (wsel && i_clear) begin
                m_tr[k] = 0; m_snz[k] = 0;
            end else if (wsel && i_snooze && m_tr[k]) begin
                m_tr[k] = 0; m_snz[k] = SNZ;
            end
        end
        m_was = i_now;
    endtask

    initial begin
        forever begin
            @(posedge i_clk);
            model_step();
            @(negedge i_clk);
            chk("cyc_tripped", 32'(o_tripped), m_trvec());
            chk("cyc_alarm", 32'(o_alarm), 32'(m_trvec() != 0));
            chk("cyc_data", o_data, m_data);
        end
    end

    function automatic logic [21:0] bcd_inc(input logic [21:0] t);
        int hh, mm, ss, tot;
        hh  = int'(t[21:20]) * 10 + int'(t[19:16]);
        mm  = int'(t[15:12]) * 10 + int'(t[11:8]);
        ss  = int'(t[7:4]) * 10 + int'(t[3:0]);
        tot = (hh * 3600 + mm * 60 + ss + 1) % 86400;
        hh  = tot / 3600;
        mm  = (tot / 60) % 60;
        ss  = tot % 60;
        return {2'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wr(input logic [LGA-1:0] a, input logic en, input logic os, input logic clr,
                      input logic snz, input logic [21:0] when, input logic [2:0] valid);
        i_wr = 1'b1; i_addr = a; i_enable = en; i_oneshot = os;
        i_clear = clr; i_snooze = snz; i_when = when; i_valid = valid;
        cyc();
        i_wr = 1'b0; i_clear = 1'b0; i_snooze = 1'b0; i_valid = 3'b000;
    endtask

    task automatic tick_to(input logic [21:0] t);
        i_now = t;
        cyc();
    endtask

    logic [21:0] t;

    initial begin
        i_reset = 1'b1; i_wr = 1'b0; i_addr = '0; i_enable = 1'b0; i_oneshot = 1'b0;
        i_clear = 1'b0; i_snooze = 1'b0; i_when = '0; i_valid = '0; i_now = '0;
        cyc(); cyc();
        chk("rst_tripped", 32'(o_tripped), 32'h0);
        chk("rst_alarm", 32'(o_alarm), 32'h0);
        chk("rst_data", o_data, 32'h0);
        i_reset = 1'b0;

        // Daily match on ch1
        wr(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 22'h120000, 3'b111);
        tick_to(22'h115959);
        chk("t1_pre", 32'(o_tripped), 32'h0);
        tick_to(22'h120000);
        chk("t1_trip", 32'(o_tripped), 32'h2);
        chk("t1_alarm", 32'(o_alarm), 32'h1);
        cyc(); cyc();
        chk("t1_hold", 32'(o_tripped), 32'h2);
        chk("t1_data", o_data, 32'h03120000);
        wr(3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 22'h0, 3'b000);
        chk("t1_clear", 32'(o_tripped), 32'h0);

        // One-shot on ch0
        wr(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 22'h000005, 3'b111);
        tick_to(22'h000003);
        tick_to(22'h000004);
        chk("t2_pre", 32'(o_tripped), 32'h0);
        tick_to(22'h000005);
        chk("t2_trip", 32'(o_tripped), 32'h1);
        cyc();
        chk("t2_data", o_data, 32'h02800005);
        wr(3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 22'h0, 3'b000);
        chk("t2_clear", 32'(o_tripped), 32'h0);
        tick_to(22'h000004);
        tick_to(22'h000005);
        cyc();
        chk("t2_noretrip", 32'(o_tripped), 32'h0);
        chk("t2_data_after", o_data, 32'h00800005);

        // Snooze on ch2: exactly SNZ ticks to re-trip, idle cycles in between must hold
        wr(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 22'h000010, 3'b111);
        tick_to(22'h000010);
        chk("t3_trip", 32'(o_tripped), 32'h4);
        wr(3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 22'h0, 3'b000);
        chk("t3_snz_untrip", 32'(o_tripped), 32'h0);
        cyc();
        chk("t3_snoozing", o_data, 32'h00400010);
        t = 22'h000010;
        for (int i = 1; i < SNZ; i++) begin
            t = bcd_inc(t);
            tick_to(t);
            if (i % 7 == 0) cyc();
        end
        chk("t3_299", 32'(o_tripped), 32'h0);
        t = bcd_inc(t);
        tick_to(t);
        chk("t3_300", 32'(o_tripped), 32'h4);
        wr(3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 22'h0, 3'b000);
        chk("t3_clear", 32'(o_tripped), 32'h0);

        // Match-trip and clear in the same cycle on ch3
        wr(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 22'h001000, 3'b111);
        i_now = 22'h001000; i_wr = 1'b1; i_addr = 3'd3; i_clear = 1'b1;
        i_enable = 1'b1; i_oneshot = 1'b0; i_valid = 3'b000;
        cyc();
        i_wr = 1'b0; i_clear = 1'b0;
        chk("t4_trip_wins", 32'(o_tripped), 32'h8);
        wr(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 22'h0, 3'b000);
        chk("t4_clear", 32'(o_tripped), 32'h0);

        // Partial field write and out-of-range address
        wr(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 22'h101010, 3'b111);
        wr(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 22'h235912, 3'b001);
        cyc();
        chk("t5_partial", o_data, 32'h00101012);
        wr(3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 22'h001001, 3'b111);
        cyc();
        chk("t5_oob_data", o_data, 32'h0);
        tick_to(22'h001001);
        chk("t5_oob_notrip", 32'(o_tripped), 32'h0);
        i_addr = 3'd1;
        cyc(); cyc();
        chk("t5_no_alias", o_data, 32'h00101012);

        // Reset while enabled and snoozing
        wr(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 22'h120000, 3'b111);
        wr(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 22'h001002, 3'b111);
        tick_to(22'h001002);
        chk("t6_trip", 32'(o_tripped), 32'h4);
        wr(3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 22'h0, 3'b000);
        chk("t6_snoozing", 32'(o_tripped), 32'h0);
        i_reset = 1'b1;
        cyc();
        chk("t6_rst_tripped", 32'(o_tripped), 32'h0);
        chk("t6_rst_alarm", 32'(o_alarm), 32'h0);
        chk("t6_rst_data", o_data, 32'h0);
        i_reset = 1'b0;
        t = 22'h001002;
        for (int i = 0; i < SNZ + 5; i++) begin
            t = bcd_inc(t);
            tick_to(t);
        end
        tick_to(22'h120000);
        cyc();
        chk("t6_no_trip", 32'(o_tripped), 32'h0);
        i_addr = 3'd0;
        cyc(); cyc();
        chk("t6_ch0_data", o_data, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
